approx_div_monitor: RTL

Parametrised, multi-cycle successor to the combinational approximate/accurate divider comparison. The block takes one dividend/divisor pair per handshake and computes an exact quotient with a bit-serial restoring divider. In parallel it computes a leading-one-based approximate quotient, then reports both quotients and their absolute error. It also keeps running error statistics for on-line accuracy characterisation of the approximate divider.

---
 rtl/approx_div_monitor_if.sv | 29 ++
 rtl/approx_div_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_div_monitor_if.sv
// Operand/result handshake bundle for approx_div_monitor.
// master = producer/consumer side, slave = divider side.
interface approx_div_monitor_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] q_acc;
  logic [DW-1:0] q_app;
  logic [DW-1:0] err;
  logic          div_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid,
    input  q_acc, q_app, err, div_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid,
    output q_acc, q_app, err, div_zero
  );
endinterface

// File: rtl/approx_div_monitor.sv
// Bit-serial exact divider beside a leading-one approximate divider,
// with running error statistics. Option macro: APPROX_DIV_COMP_EN.
module approx_div_monitor #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int SW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  approx_div_monitor_if.slave bus,
  input  logic                clear_stats,
  output logic [SW-1:0]       err_sum,
  output logic [DW-1:0]       err_max,
  output logic [SW-1:0]       count
);
  localparam int PW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    HOLD
  } state_t;

  state_t        state;
  state_t        nstate;
  logic          started;
  logic [DW-1:0] a_r;
  logic [VW-1:0] b_r;
  logic [DW-1:0] dq;
  logic [VW-1:0] rem;
  logic [PW-1:0] cnt;
  logic [DW-1:0] q_acc_r;
  logic [DW-1:0] q_app_r;
  logic [DW-1:0] err_r;
  logic          dz_r;
  logic          take;

  logic [VW:0]   rem_sh;
  logic [VW-1:0] rem_df;
  logic [VW-1:0] rem_nx;
  logic          ge;
  logic [DW-1:0] q_nx;
  logic [DW-1:0] err_nx;

  logic [DW-1:0] b_ext;
  logic [PW-1:0] pa;
  logic [PW-1:0] pb;
  logic [PW-1:0] sh;
  logic [DW-1:0] app;
`ifdef APPROX_DIV_COMP_EN
  logic          a_nb;
  logic          b_nb;
`endif

  logic          upd;
  logic [SW-1:0] sum_b;
  logic [SW-1:0] cnt_b;
  logic [DW-1:0] max_b;
  logic [SW:0]   sum_w;
  logic [SW-1:0] sum_nx;
  logic [SW-1:0] cnt_nx;
  logic [DW-1:0] max_nx;

  function automatic logic [PW-1:0] lead1(
    input logic [DW-1:0] v
  );
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < DW; i++)
      if (v[i]) p = PW'(i);
    return p;
  endfunction

  assign take = bus.in_valid && bus.in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state decode
  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (take)
              nstate = (bus.b == '0) ? HOLD : DIV;
      DIV:  if (cnt == '0) nstate = HOLD;
      HOLD: if (bus.out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.in_ready  = started && (state == IDLE);
    bus.out_valid = (state == HOLD);
  end

  assign bus.q_acc    = q_acc_r;
  assign bus.q_app    = q_app_r;
  assign bus.err      = err_r;
  assign bus.div_zero = dz_r;

  // One restoring step, MSB first
  always_comb begin
    rem_sh = {rem, dq[DW-1]};
    ge     = rem_sh >= {1'b0, b_r};
    rem_df = VW'(rem_sh - {1'b0, b_r});
    rem_nx = ge ? rem_df : rem_sh[VW-1:0];
    q_nx   = {dq[DW-2:0], ge};
  end

  // Leading-one approximate quotient
  always_comb begin
    b_ext = DW'(b_r);
    pa    = lead1(a_r);
    pb    = lead1(b_ext);
    sh    = pa - pb;
    app   = '0;
`ifdef APPROX_DIV_COMP_EN
    a_nb  = 1'b0;
    b_nb  = 1'b0;
`endif
    if (a_r != '0 && pa >= pb) begin
      app = DW'(1) << sh;
`ifdef APPROX_DIV_COMP_EN
      if (pa > pb) begin
        a_nb = |(a_r & (DW'(1) << (pa - PW'(1))));
        b_nb = (pb != '0) &&
               |(b_ext & (DW'(1) << (pb - PW'(1))));
        if (a_nb && !b_nb)
          app = app | (DW'(1) << (sh - PW'(1)));
      end
`endif
    end
    err_nx = (q_nx >= app) ? q_nx - app : app - q_nx;
  end

  // Operand latch, divider iteration, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      dq      <= '0;
      rem     <= '0;
      cnt     <= '0;
      q_acc_r <= '0;
      q_app_r <= '0;
      err_r   <= '0;
      dz_r    <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: if (take) begin
          a_r <= bus.a;
          b_r <= bus.b;
          dq  <= bus.a;
          rem <= '0;
          cnt <= PW'(DW - 1);
          if (bus.b == '0) begin
            q_acc_r <= '1;
            q_app_r <= '1;
            err_r   <= '0;
            dz_r    <= 1'b1;
          end
        end
        DIV: begin
          dq  <= q_nx;
          rem <= rem_nx;
          cnt <= cnt - PW'(1);
          if (cnt == '0) begin
            q_acc_r <= q_nx;
            q_app_r <= app;
            err_r   <= err_nx;
            dz_r    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next statistics: optional clear, then add this sample
  always_comb begin
    upd    = bus.out_valid && bus.out_ready && !dz_r;
    sum_b  = clear_stats ? '0 : err_sum;
    cnt_b  = clear_stats ? '0 : count;
    max_b  = clear_stats ? '0 : err_max;
    sum_w  = {1'b0, sum_b} + (SW+1)'(err_r);
    sum_nx = sum_b;
    cnt_nx = cnt_b;
    max_nx = max_b;
    if (upd) begin
      sum_nx = sum_w[SW] ? '1 : sum_w[SW-1:0];
      cnt_nx = (&cnt_b) ? cnt_b : cnt_b + SW'(1);
      max_nx = (err_r > max_b) ? err_r : max_b;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum <= '0;
      err_max <= '0;
      count   <= '0;
    end else begin
      err_sum <= sum_nx;
      err_max <= max_nx;
      count   <= cnt_nx;
    end
  end
endmodule
